// File: rtl/fft_transpose_buf.sv
// fft_transpose_buf: ping-pong 4x4 corner-turn buffer between the stage-1 and stage-2 radix-4 passes.
// Optional macro FFT_TRBUF_FRAME_CNT_EN adds the 8-bit drained-frame counter output frame_cnt.
module fft_transpose_buf #(
   parameter  int DW = 17,
   localparam int CW = 2 * DW,
   localparam int BW = 8 * DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [BW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [BW-1:0] out_data,
   output logic [2:0]    out_rotation,
   input  logic          out_ready
`ifdef FFT_TRBUF_FRAME_CNT_EN
   ,
   output logic [7:0]    frame_cnt
`endif
);

   logic [CW-1:0] mem [2][4][4];
   logic [1:0]    full;
   logic [1:0]    full_nxt;
   logic          wr_bank;
   logic          rd_bank;
   logic [1:0]    wr_row;
   logic [1:0]    rd_col;
   logic          wr_en;
   logic          rd_en;

   // Ready comes only from registered state (plus reset), never from in_valid.
   assign in_ready  = !rst && !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign wr_en     = in_valid && in_ready;
   assign rd_en     = out_valid && out_ready;

   // Writer only touches a non-full bank and reader only a full one, so the two updates never collide.
   always_comb begin
      full_nxt = full;
      if (wr_en && (wr_row == 2'd3))
         full_nxt[wr_bank] = 1'b1;
      if (rd_en && (rd_col == 2'd3))
         full_nxt[rd_bank] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_row  <= 2'd0;
         rd_col  <= 2'd0;
      end else begin
         full <= full_nxt;
         if (wr_en) begin
            wr_row <= wr_row + 2'd1;
            if (wr_row == 2'd3)
               wr_bank <= ~wr_bank;
         end
         if (rd_en) begin
            rd_col <= rd_col + 2'd1;
            if (rd_col == 2'd3)
               rd_bank <= ~rd_bank;
         end
      end
   end

   // Storage is not reset; the full flags alone decide what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++)
            mem[wr_bank][wr_row][k] <= in_data[CW*k +: CW];
      end
   end

   always_comb begin
      out_data     = '0;
      out_rotation = 3'b000;
      if (out_valid) begin
         for (int r = 0; r < 4; r++)
            out_data[CW*r +: CW] = mem[rd_bank][r][rd_col];
         out_rotation = {1'b1, rd_col};
      end
   end

`ifdef FFT_TRBUF_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         frame_cnt <= 8'd0;
      else if (rd_en && (rd_col == 2'd3))
         frame_cnt <= frame_cnt + 8'd1;
   end
`endif

endmodule

// File: doc/fft_transpose_buf.md
Name: fft_transpose_buf

Overview:
- Inter-stage corner-turn buffer for the 16-point radix-4 FFT.
- Sits between the stage-1 and stage-2 passes of the combinational butterfly.
- Collects the four 136-bit stage-1 butterfly outputs of one frame and emits them column-transposed, each with its stage-2 rotation code.
- Ping-pong banks let one frame be written while the previous frame drains, giving full 1-word/cycle throughput.

Parameters:
- DW, 17: width of one real or imaginary component (sign + 8 integer + 8 fraction, 2's complement).
- CW, 2*DW: width of one complex word, {Re, Im}; derived, not overridden.
- BW, 8*DW: bus width, four complex words (136 at default); derived.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  stage-1 output word present.
- in_data  in  BW  stage-1 butterfly output; lane k = bits [CW*k+CW-1 : CW*k].
- in_ready  out  1  buffer can accept in_data this cycle.
- out_valid  out  1  transposed word available.
- out_data  out  BW  transposed word to the stage-2 butterfly.
- out_rotation  out  3  stage-2 rotation code for out_data.
- out_ready  in  1  downstream accepts out_data this cycle.

Behaviour:
- Storage: two banks (0, 1), each a 4x4 array of CW-bit words M[b][row][lane].
- Control flags per bank: full[b].
- Pointers: wr_bank, wr_row (0..3), rd_bank, rd_col (0..3).
- Reset (sync, rst=1 at a rising edge):
  - full[*]=0; all pointers 0.
  - out_valid=0, out_data=0, out_rotation=0.
  - in_ready=0 while rst is high.
  - Array contents need not be cleared.
- in_ready = !rst && !full[wr_bank], decoded from registers, with no combinational path from in_valid.
- Write (in_valid && in_ready):
  - M[wr_bank][wr_row][k] <= lane k of in_data; wr_row++.
  - If wr_row==3: full[wr_bank]<=1, wr_row<=0, wr_bank toggles.
- in_valid with in_ready=0: the word is ignored; upstream must hold it.
- out_valid = full[rd_bank].
- out_data = {M[rd_bank][3][rd_col], M[rd_bank][2][rd_col], M[rd_bank][1][rd_col], M[rd_bank][0][rd_col]} when out_valid=1, else all zeros.
- out_rotation = {1'b1, rd_col[1:0]} when out_valid=1, else 3'b000.
- Read (out_valid && out_ready):
  - rd_col++.
  - If rd_col==3: full[rd_bank]<=0, rd_col<=0, rd_bank toggles.
- out_valid with out_ready=0: out_data and out_rotation are held stable.
- Latency: the row-3 write of a frame at edge k gives out_valid=1 in the cycle after edge k, showing column 0.
- Throughput: with in_valid and out_ready held at 1, in_ready never drops after the first frame.
  - A bank freed at edge k is writable in cycle k+1.
- Simultaneous write and read in one cycle always address different banks: a bank is written only when not full and read only when full. Both operations occur.
- Both banks full: in_ready=0 until the read side frees a bank.
- Pointer wrap: wr_row, rd_col and the bank pointers wrap modulo 4 and modulo 2.
- Reset mid-frame discards all partial and full frames; the next accepted word is row 0 of bank 0.
- No arithmetic is performed; data passes through bit-exact.

Optional Feature:
- Macro: FFT_TRBUF_FRAME_CNT_EN.
- When defined, adds output port frame_cnt (out, 8 bits).
  - Reset value 0.
  - Increments on each read handshake with rd_col==3, i.e. each fully drained frame.
  - Wraps from 255 to 0.
- When undefined, the port and counter do not exist and the remaining behaviour is identical.

Test Plan:
- Test vectors: word w(r,c) has Re = 16*r+c (17-bit), Im = 0.
- Single frame: write rows 0..3, row r lanes {w(r,3), w(r,2), w(r,1), w(r,0)}, out_ready=1.
  - out_valid rises the cycle after the row-3 write.
  - Column j: out_data={w(3,j), w(2,j), w(1,j), w(0,j)} and out_rotation=3'b100+j, for j=0..3 on consecutive cycles.
  - Then out_valid=0 and out_data=0.
- Streaming: 3 back-to-back frames with in_valid=1 and out_ready=1 throughout.
  - in_ready stays 1 for all 12 writes.
  - 12 outputs in order, each frame transposed correctly.
- Backpressure: out_ready=0 while writing 2 frames.
  - in_ready=0 after the 8th write; a 9th word is not accepted.
  - Raising out_ready for 4 cycles re-asserts in_ready in the next cycle.
  - out_data is stable while stalled.
- Mid-drain stall: out_ready toggles 1,0,1,0,...
  - Each column appears exactly once; out_rotation advances only on handshake.
- Reset mid-frame: assert rst after row 2 of a frame.
  - out_valid=0 and in_ready=0 during reset.
  - A new full frame is then transposed with no residue from the aborted frame.
- FFT_TRBUF_FRAME_CNT_EN defined: drain 257 frames.
  - frame_cnt increments at each frame's 4th read and ends at 1.
